llr_bram_port_arbiter: RTL and testbench

- Shares port A of the LLR init BRAM between two requesters:
  - the input writer, which stores incoming channel LLRs;
  - the LLR calculator reader, which fetches stage-0 operands.
- Grants at most one access per cycle.
- Write has fixed priority; starvation protection guarantees the reader a slot within a bounded number of cycles.
- Sits between the input/LLR controllers and the BRAM. The BRAM has 1-cycle read latency and no output register.

---
 rtl/llr_bram_port_arbiter_if.sv | 34 +++
 rtl/llr_bram_port_arbiter.sv | 121 ++++++++++++
 tb/tb_llr_bram_port_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/llr_bram_port_arbiter_if.sv
// Bundle of the writer, reader and BRAM port-A signals shared by the LLR init BRAM arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface llr_bram_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_grant;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_grant;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_di;
  logic                  bram_en;
  logic                  bram_we;
  logic [DATA_WIDTH-1:0] bram_do;
  logic                  starve_active;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, bram_do,
    output wr_grant, rd_grant, rd_data, rd_data_valid,
           bram_addr, bram_di, bram_en, bram_we, starve_active
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, bram_do,
    input  wr_grant, rd_grant, rd_data, rd_data_valid,
           bram_addr, bram_di, bram_en, bram_we, starve_active
  );
endinterface

// File: rtl/llr_bram_port_arbiter.sv
// Shares BRAM port A between the LLR input writer and the stage-0 reader.
// Writes win by default; a reader denied STARVE_LIMIT cycles in a row is forced through.
module llr_bram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH       = 10,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned STARVE_LIMIT     = 4,
  parameter int unsigned STARVE_CNT_WIDTH = 3
) (
  input logic                     clk_i,
  input logic                     reset_ni,
  llr_bram_port_arbiter_if.slave  bus_io
);

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

  localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_MAX = STARVE_CNT_WIDTH'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_WIDTH-1:0] CNT_ONE    = STARVE_CNT_WIDTH'(1);

  logic [STARVE_CNT_WIDTH-1:0] starve_cnt_q;
  logic [STARVE_CNT_WIDTH-1:0] starve_cnt_d;
  op_e                         last_op_q;
  op_e                         last_op_d;

  logic                  starve_s;
  logic                  rd_grant_s;
  logic                  wr_grant_s;
  logic                  bram_en_s;
  logic                  bram_we_s;
  logic [ADDR_WIDTH-1:0] bram_addr_s;
  logic [DATA_WIDTH-1:0] bram_di_s;
  logic                  rd_valid_s;

  // Same-cycle arbitration; everything is held low while reset is asserted.
  always_comb begin
    starve_s   = 1'b0;
    rd_grant_s = 1'b0;
    wr_grant_s = 1'b0;
    if (reset_ni) begin
      starve_s   = bus_io.rd_req && (starve_cnt_q == STARVE_MAX);
      rd_grant_s = bus_io.rd_req && (!bus_io.wr_req || starve_s);
      wr_grant_s = bus_io.wr_req && !rd_grant_s;
    end else begin
      starve_s   = 1'b0;
      rd_grant_s = 1'b0;
      wr_grant_s = 1'b0;
    end
  end

  // Port-A drive follows whichever requester holds the grant.
  always_comb begin
    bram_en_s   = 1'b0;
    bram_we_s   = 1'b0;
    bram_addr_s = '0;
    bram_di_s   = '0;
    if (wr_grant_s) begin
      bram_en_s   = 1'b1;
      bram_we_s   = 1'b1;
      bram_addr_s = bus_io.wr_addr;
      bram_di_s   = bus_io.wr_data;
    end else if (rd_grant_s) begin
      bram_en_s   = 1'b1;
      bram_we_s   = 1'b0;
      bram_addr_s = bus_io.rd_addr;
      bram_di_s   = '0;
    end else begin
      bram_en_s   = 1'b0;
      bram_we_s   = 1'b0;
      bram_addr_s = '0;
      bram_di_s   = '0;
    end
  end

  // Next starvation count and next operation record.
  always_comb begin
    starve_cnt_d = '0;
    last_op_d    = OP_IDLE;
    if (bus_io.rd_req && !rd_grant_s) begin
      if (starve_cnt_q == STARVE_MAX) begin
        starve_cnt_d = STARVE_MAX;
      end else begin
        starve_cnt_d = starve_cnt_q + CNT_ONE;
      end
    end else begin
      starve_cnt_d = '0;
    end
    case ({wr_grant_s, rd_grant_s})
      2'b10:   last_op_d = OP_WRITE;
      2'b01:   last_op_d = OP_READ;
      default: last_op_d = OP_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      starve_cnt_q <= '0;
      last_op_q    <= OP_IDLE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      last_op_q    <= last_op_d;
    end
  end

  // Gating with reset drops the return of a read whose grant was followed by reset.
  assign rd_valid_s = reset_ni && (last_op_q == OP_READ);

  assign bus_io.wr_grant      = wr_grant_s;
  assign bus_io.rd_grant      = rd_grant_s;
  assign bus_io.starve_active = starve_s;
  assign bus_io.bram_en       = bram_en_s;
  assign bus_io.bram_we       = bram_we_s;
  assign bus_io.bram_addr     = bram_addr_s;
  assign bus_io.bram_di       = bram_di_s;
  assign bus_io.rd_data_valid = rd_valid_s;
  assign bus_io.rd_data       = rd_valid_s ? bus_io.bram_do : '0;

endmodule

// File: tb/tb_llr_bram_port_arbiter.sv
// Randomized and directed bench for llr_bram_port_arbiter with a behavioural BRAM,
// a shadow-memory reference model, and a per-cycle compare on the falling edge.
module tb_llr_bram_port_arbiter;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int LIMIT = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  llr_bram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  llr_bram_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT), .STARVE_CNT_WIDTH(3)
  ) dut (
    .clk_i(clk), .reset_ni(rst_n), .bus_io(bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  // Behavioural BRAM: output changes only on an enabled read.
  always @(posedge clk) begin
    if (bif.bram_en) begin
      if (bif.bram_we) mem[bif.bram_addr] <= bif.bram_di;
      else             bif.bram_do <= mem[bif.bram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: how many cycles in a row the reader has been turned away,
  // plus what the reader is owed next cycle.
  int            denied;
  bit            exp_valid;
  logic [DW-1:0] exp_data;

  function automatic void decide(input bit wr, input bit rd, input int waited,
                                 output bit rg, output bit wg, output bit forced);
    forced = rd && (waited >= LIMIT);
    rg     = rd && (forced || !wr);
    wg     = wr && !rg;
  endfunction

  always @(posedge clk) begin
    bit rg, wg, st;
    if (!rst_n) begin
      denied    = 0;
      exp_valid = 1'b0;
    end else begin
      decide(bif.wr_req, bif.rd_req, denied, rg, wg, st);
      exp_valid = rg;
      if (rg) exp_data = shadow[bif.rd_addr];
      if (wg) shadow[bif.wr_addr] = bif.wr_data;
      if (bif.rd_req && !rg) denied = (denied + 1 > LIMIT) ? LIMIT : denied + 1;
      else                   denied = 0;
    end
  end

  bit wg_seen, rg_seen;

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit rg, wg, st;
    if (!rst_n) begin
      rg = 1'b0; wg = 1'b0; st = 1'b0;
    end else begin
      decide(bif.wr_req, bif.rd_req, denied, rg, wg, st);
    end
    chk("wr_grant", 32'(bif.wr_grant), 32'(wg));
    chk("rd_grant", 32'(bif.rd_grant), 32'(rg));
    chk("starve_active", 32'(bif.starve_active), 32'(st));
    chk("bram_en", 32'(bif.bram_en), 32'(wg || rg));
    chk("bram_we", 32'(bif.bram_we), 32'(wg));
    chk("bram_addr", 32'(bif.bram_addr), wg ? 32'(bif.wr_addr) : (rg ? 32'(bif.rd_addr) : 32'd0));
    chk("bram_di", 32'(bif.bram_di), wg ? 32'(bif.wr_data) : 32'd0);
    chk("rd_data_valid", 32'(bif.rd_data_valid), 32'(rst_n && exp_valid));
    chk("rd_data", 32'(bif.rd_data), (rst_n && exp_valid) ? 32'(exp_data) : 32'd0);
    wg_seen = bif.wr_grant;
    rg_seen = bif.rd_grant;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit wr, input int wa, input int wd, input bit rd, input int ra);
    bif.wr_req  = wr;
    bif.wr_addr = AW'(wa);
    bif.wr_data = DW'(wd);
    bif.rd_req  = rd;
    bif.rd_addr = AW'(ra);
  endtask

  initial begin
    logic [9:0] rpat, spat, vpat;
    logic [7:0] dpat;
    logic [4:0] qpat;
    checks = 0;
    errors = 0;
    denied = 0;
    exp_valid = 1'b0;
    exp_data = '0;
    bif.bram_do = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    rst_n = 1'b0;
    drive(1'b1, 0, 0, 1'b1, 0);

    // Reset held with both requesting: nothing granted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_wr_grant", 32'(bif.wr_grant), 32'd0);
      chk("rst_rd_grant", 32'(bif.rd_grant), 32'd0);
      chk("rst_bram_en", 32'(bif.bram_en), 32'd0);
      chk("rst_valid", 32'(bif.rd_data_valid), 32'd0);
      step();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_wr_grant", 32'(bif.wr_grant), 32'd1);
    step();

    // Writes of 0..7.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i, 8'h10 + i, 1'b0, 0);
      @(negedge clk);
      chk("wonly_grant", 32'(bif.wr_grant), 32'd1);
      chk("wonly_we", 32'(bif.bram_we), 32'd1);
      chk("wonly_valid", 32'(bif.rd_data_valid), 32'd0);
      step();
    end

    // Reads of 0..7, data due one cycle after each grant.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 0, 0, i < 8, i);
      @(negedge clk);
      if (i > 0) begin
        chk("ronly_valid", 32'(bif.rd_data_valid), 32'd1);
        chk("ronly_data", 32'(bif.rd_data), 32'h10 + 32'(i - 1));
      end
      step();
    end

    // Both requesting continuously: W,W,W,W,R repeating.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 100 + i, i, 1'b1, i);
      @(negedge clk);
      rpat[i] = bif.rd_grant;
      spat[i] = bif.starve_active;
      vpat[i] = bif.rd_data_valid;
      step();
    end
    chk("both_rd_pattern", 32'(rpat), 32'b10_0001_0000);
    chk("both_starve_pattern", 32'(spat), 32'b10_0001_0000);
    chk("both_valid_pattern", 32'(vpat), 32'b00_0010_0000);

    // Reader backs off after 2 denials: counting restarts.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 200, i, i != 2, 1);
      @(negedge clk);
      dpat[i] = bif.rd_grant;
      step();
    end
    chk("drop_rd_pattern", 32'(dpat), 32'b1000_0000);

    // Read granted, then reset: its return is suppressed.
    drive(1'b0, 0, 0, 1'b1, 5);
    @(negedge clk);
    chk("pre_rst_rd_grant", 32'(bif.rd_grant), 32'd1);
    step();
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0, 0);
    @(negedge clk);
    chk("mid_rst_valid", 32'(bif.rd_data_valid), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 300, i, 1'b1, 2);
      @(negedge clk);
      qpat[i] = bif.rd_grant;
      step();
    end
    chk("post_rst_pattern", 32'(qpat), 32'b1_0000);

    // Read of 3 then immediate write of 3: returned word is the old one.
    drive(1'b1, 3, 8'hA5, 1'b0, 0);
    step();
    drive(1'b0, 0, 0, 1'b1, 3);
    step();
    drive(1'b1, 3, 8'h5A, 1'b0, 0);
    @(negedge clk);
    chk("rw_old_valid", 32'(bif.rd_data_valid), 32'd1);
    chk("rw_old_data", 32'(bif.rd_data), 32'hA5);
    step();
    drive(1'b0, 0, 0, 1'b1, 3);
    step();
    drive(1'b0, 0, 0, 1'b0, 0);
    @(negedge clk);
    chk("rw_new_data", 32'(bif.rd_data), 32'h5A);
    step();

    // Random traffic with hold-until-granted requesters and occasional reset.
    for (int n = 0; n < 600; n++) begin
      if (!bif.wr_req || wg_seen) begin
        bif.wr_req  = ($urandom_range(0, 3) != 0);
        bif.wr_addr = AW'($urandom_range(0, 15));
        bif.wr_data = DW'($urandom);
      end
      if (!bif.rd_req || rg_seen) begin
        bif.rd_req  = ($urandom_range(0, 2) != 0);
        bif.rd_addr = AW'($urandom_range(0, 15));
      end else if ($urandom_range(0, 9) == 0) begin
        bif.rd_addr = AW'($urandom_range(0, 15));
      end
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
